// File: rtl/pipe_stage_reg.sv
// Purpose : inter-stage pipeline register (valid/ready) with flush and control-bubble gating.
// Latency : one falling edge from accepted input to out_valid with that entry.
// Backpres: in_ready = !out_valid || out_ready (comb); with PIPE_STAGE_SKID_EN, in_ready = !skid_valid (flop).
//
// Optional feature macro: PIPE_STAGE_SKID_EN (adds one skid entry, registers in_ready).
//
// Ports:
//   clk        stage clock, all state changes on the falling edge
//   rst_n      asynchronous active-low reset
//   flush      squash held and incoming entries at this edge
//   in_valid / in_ready / in_ctrl / in_data      upstream handshake and entry
//   out_valid / out_ready / out_ctrl / out_data  downstream handshake and entry
//   stall_cnt  saturating count of edges with out_valid && !out_ready
module pipe_stage_reg #(
  parameter int DATA_W      = 101,
  parameter int CTRL_W      = 6,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t in_ent;
  entry_t main_q;
  logic   main_load;
  logic   take_in;

  assign in_ent    = {in_ctrl, in_data};
  assign main_load = !out_valid || out_ready;
  // A flush discards the incoming entry even when in_ready is high.
  assign take_in   = in_valid && in_ready && !flush;

  assign out_data  = main_q.data;
  // Invalid slots never present live control bits downstream.
  assign out_ctrl  = out_valid ? main_q.ctrl : '0;

`ifdef PIPE_STAGE_SKID_EN
  logic   skid_valid;
  entry_t skid_q;

  // Registered ready: no combinational path from out_ready.
  assign in_ready = !skid_valid;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (flush) begin
      // Payload is left in place; only the valid flags are squashed.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_load) begin
      if (skid_valid) begin
        // Older skid entry goes first; in_ready was low so no input arrives now.
        main_q     <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (take_in) begin
        main_q    <= in_ent;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (take_in) begin
      // Main is stalled: park the accepted entry and drop in_ready.
      skid_q     <= in_ent;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = main_load;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      main_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (main_load) begin
      if (take_in) begin
        main_q    <= in_ent;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
`endif

  // Stall counter ignores flush; only reset clears it.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int DATA_W      = 101;
  localparam int CTRL_W      = 6;
  localparam int STALL_CNT_W = 4;
  localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;
  localparam logic [CTRL_W-1:0] C = 6'b100001;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_W-1:0]      in_ctrl;
  logic [DATA_W-1:0]      in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_W-1:0]      out_ctrl;
  logic [DATA_W-1:0]      out_data;
  logic [STALL_CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is an ordered queue holding at most 1 (plain) or 2 (skid) entries.
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              q[$];
  ent_t              m_new;
  logic [DATA_W-1:0] m_data;
  int                m_stall;
  bit                m_acc;

  function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_data  = '0;
      m_stall = 0;
    end else begin
      m_acc = in_valid && m_in_ready();
      if (q.size() > 0 && !out_ready && m_stall < STALL_MAX) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (m_acc) begin
          m_new.c = in_ctrl;
          m_new.d = in_data;
          q.push_back(m_new);
        end
      end
      if (q.size() > 0) m_data = q[0].d;
    end
  end

  // Compare every cycle, half a period away from the active (falling) edge.
  always @(posedge clk) begin
    #2;
    chk("cmp_out_valid", out_valid, q.size() > 0);
    chk("cmp_out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
    chk("cmp_out_data", out_data, m_data);
    chk("cmp_stall_cnt", stall_cnt, m_stall);
    chk("cmp_in_ready", in_ready, m_in_ready());
  end

  // Apply one vector at the rising edge; return just after the following falling edge.
  task automatic cyc(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                     input logic ordy, input logic fl);
    @(posedge clk);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    rst_n = 1'b1;

    // Streaming at full rate.
    cyc(1, C, 1, 1, 0);
    chk("stream_d1", out_data, 1);
    chk("stream_c1", out_ctrl, 6'b100001);
    cyc(1, C, 2, 1, 0);
    chk("stream_d2", out_data, 2);
    cyc(1, C, 3, 1, 0);
    chk("stream_d3", out_data, 3);
    chk("stream_valid3", out_valid, 1);
    chk("stream_stall", stall_cnt, 0);

    // Bubble: invalid input with all control bits set.
    cyc(0, 6'b111111, 0, 1, 0);
    chk("bubble_valid", out_valid, 0);
    chk("bubble_ctrl", out_ctrl, 0);
    chk("bubble_hold_data", out_data, 3);

    // Stall for 3 edges while offering 0xB then 0xC.
    cyc(1, C, 'hA, 1, 0);
    chk("stall_load_a", out_data, 'hA);
    cyc(1, C, 'hB, 0, 0);
    chk("stall_in_ready", in_ready, 0);
    cyc(1, C, 'hC, 0, 0);
    cyc(1, C, 'hC, 0, 0);
    chk("stall_hold_a", out_data, 'hA);
    chk("stall_cnt3", stall_cnt, 3);
    cyc(1, C, 'hC, 1, 0);
`ifdef PIPE_STAGE_SKID_EN
    chk("release_b", out_data, 'hB);
`else
    chk("release_c", out_data, 'hC);
`endif
    cyc(1, C, 'hC, 1, 0);
    chk("release_c2", out_data, 'hC);
    cyc(0, C, 0, 1, 0);
    chk("release_empty", out_valid, 0);

    // Saturation: 20 stalled edges on top of the earlier 3.
    cyc(1, C, 'hE, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, C, 0, 0, 0);
    chk("sat_stall_cnt", stall_cnt, 15);

    // Flush with a held entry and 0xD offered.
    cyc(1, C, 'hD, 0, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_keep_data", out_data, 'hE);
    cyc(0, C, 0, 1, 0);
    chk("flush_no_d", out_valid, 0);
    chk("flush_stall_kept", stall_cnt, 15);

    // Flush while the skid (if present) is occupied, together with out_ready.
    cyc(1, C, 'h11, 1, 0);
    cyc(1, C, 'h12, 0, 0);
    cyc(1, C, 'h13, 1, 1);
    chk("flush2_valid", out_valid, 0);
    cyc(0, C, 0, 1, 0);
    chk("flush2_skid_gone", out_valid, 0);
    chk("flush2_ready", in_ready, 1);

    // Asynchronous reset mid-stream with a valid entry held.
    cyc(1, C, 'h21, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    rst_n = 1'b1;

    // Mixed pattern: gaps, stalls and one flush, checked by the model each cycle.
    for (int i = 0; i < 40; i++)
      cyc((i % 3) != 0, CTRL_W'(i), DATA_W'(i + 'h100), (i % 4) != 1, i == 17);

    cyc(0, C, 0, 1, 0);
    cyc(0, C, 0, 1, 0);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with valid/ready flow control, flush, and control-bubble insertion. It is the successor to the fixed pass-through stage registers: one instance sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB). Data and control fields are carried as generic buses so that every stage boundary uses the same block. Optionally, a skid entry decouples `in_ready` from `out_ready`.

## Interface
- `DATA_W`, default 101: width of the datapath payload (ALU result, store data, immediate, destination register).
- `CTRL_W`, default 6: width of control bits (RegWrite, MemtoReg, Branch, MemRead, MemWrite, zero).
- `STALL_CNT_W`, default 16: width of the stall-cycle counter.
- `clk`  in  1  stage clock; all state updates on the falling edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  squash all held and incoming entries at this edge.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  block accepts the entry at this edge.
- `in_ctrl`  in  CTRL_W  upstream control bits.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream entry valid.
- `out_ready`  in  1  downstream consumes the entry at this edge.
- `out_ctrl`  out  CTRL_W  control bits; forced to 0 whenever `out_valid`=0.
- `out_data`  out  DATA_W  payload; holds its last value when invalid.
- `stall_cnt`  out  STALL_CNT_W  saturating count of stalled edges.

## Operation
- Transfer in: occurs when `in_valid && in_ready` at a falling edge. Transfer out: occurs when `out_valid && out_ready`.
- Main register: `out_valid`, `out_ctrl_q`, `out_data`.
- `out_ctrl` = `out_valid ? out_ctrl_q : 0`. This combinational bubble guarantees that an invalid slot never writes the register file or memory.
- Main register loads when it is empty or being consumed (`!out_valid || out_ready`):
  - The skid entry (when the skid is enabled and holds an entry) takes priority. Otherwise the accepted input is loaded. Otherwise `out_valid` goes to 0.
- `flush` overrides everything at that edge:
  - `out_valid` and the skid valid flag clear.
  - The incoming entry is discarded, even if `in_ready`=1.
  - `out_data` is not cleared.
- `stall_cnt` increments at each edge with `out_valid && !out_ready` and saturates at all-ones. It is cleared only by reset and is unaffected by `flush`.
- Reset (asynchronous assert, any time including mid-transfer):
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `stall_cnt`=0, skid empty.
  - `in_ready` goes to 1 in the skid build and follows `out_ready` logic in the non-skid build.
- Reset release is synchronous to the next falling edge in behaviour; no transfer occurs while `rst_n`=0.
- Ordering: entries leave in acceptance order. There is no duplication or loss except through `flush`.

## Timing
- Latency: one falling edge from accepted input to `out_valid`=1 with that data.
- Throughput: one entry per edge when `out_ready` is held at 1.
- Non-skid build: `in_ready` = `!out_valid || out_ready`. This is a combinational path from `out_ready`.
- Skid build: `in_ready` = `!skid_valid`, driven directly from a flop. No combinational path from `out_ready` to `in_ready`.
- `out_ready` falling while an input is accepted (skid build): the input is captured into the skid and `in_ready` drops at the same edge. At the next edge with `out_ready`=1, the skid moves to main. If `in_valid` is also present, the input is accepted only after the skid empties.
- Simultaneous `flush` and `out_ready`: the flush wins and the held entry is not reported as transferred. Downstream must ignore the edge's consumption.

## Configuration
- Macro: `PIPE_STAGE_SKID_EN`.
- Defined: adds one skid entry (`DATA_W`+`CTRL_W`+1 flops). `in_ready` is registered, giving full throughput across a one-edge downstream stall.
- Undefined: no skid storage. `in_ready` is combinational from `out_ready` and the block is a single register. Port list and reset values are identical in both builds.

## Test plan
- Reset: drive `rst_n`=0 mid-stream with `out_valid`=1 → immediately `out_valid`=0, `out_ctrl`=0, `out_data`=0, `stall_cnt`=0.
- Streaming: hold `out_ready`=1 and present `in_data`=0x1, 0x2, 0x3 on consecutive edges with `in_ctrl`=6'b100001 → outputs 0x1, 0x2, 0x3 one edge later, no gaps, `stall_cnt`=0.
- Stall (skid build): after accepting 0xA, drop `out_ready` for 3 edges while offering 0xB then 0xC → 0xB enters the skid and `in_ready`=0. Output holds 0xA. `stall_cnt`=3. On release, order is 0xA, 0xB, 0xC.
- Flush: with an entry held and `in_valid`=1 carrying 0xD, pulse `flush` → next edge `out_valid`=0 and `out_ctrl`=0. 0xD never appears at the output.
- Bubble: `in_valid`=0 with `in_ctrl`=6'b111111 → `out_ctrl` stays 0.
- Saturation: with `STALL_CNT_W`=4, stall for 20 edges → `stall_cnt`=15.
